// File: rtl/hazard_tracker_if.sv
// hazard_tracker_if: D-stage hazard query and stage-tag export between the
// pipeline control (master) and the hazard tracker (slave).
//   D inputs : d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
//              d_md_op, d_md_use
//   Outputs  : stall (combinational), e_dst, m_dst, w_dst, e_tnew, m_tnew,
//              md_busy, md_count
interface hazard_tracker_if;
    logic       d_valid;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] d_tuse_rs;
    logic [1:0] d_tuse_rt;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;
    logic [1:0] d_md_op;
    logic       d_md_use;
    logic       stall;
    logic [4:0] e_dst;
    logic [4:0] m_dst;
    logic [4:0] w_dst;
    logic [1:0] e_tnew;
    logic [1:0] m_tnew;
    logic       md_busy;
    logic [3:0] md_count;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_op, d_md_use,
        input  stall, e_dst, m_dst, w_dst, e_tnew, m_tnew, md_busy, md_count
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_op, d_md_use,
        output stall, e_dst, m_dst, w_dst, e_tnew, m_tnew, md_busy, md_count
    );
endinterface

// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks destination/Tnew tags of instructions in E, M and W,
// raises a same-cycle stall when forwarding cannot satisfy the D-stage
// operand deadlines (Tuse), and owns the mult/div busy counter.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low clear of all state
//   hz    : hazard_tracker_if.slave (D query in, stall and stage tags out)
module hazard_tracker #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic            clk,
    input  logic            reset,
    hazard_tracker_if.slave hz
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned CNT_W  = 4;

    logic [REG_W-1:0]  e_dst;
    logic [REG_W-1:0]  m_dst;
    logic [REG_W-1:0]  w_dst;
    logic [TNEW_W-1:0] e_tnew;
    logic [TNEW_W-1:0] m_tnew;
    logic [TNEW_W-1:0] e_tnew_dec;
    logic [CNT_W-1:0]  md_count;
    logic              md_busy;
    logic              stall_rs;
    logic              stall_rt;
    logic              stall_md;
    logic              stall;
    logic              issue_md;

    // A source hits when a not-yet-ready producer in E or M writes it.
    // W always has Tnew 0 so it is never consulted; $0 never matches.
    function automatic logic raw_hit(
        input logic [REG_W-1:0]  src,
        input logic [TNEW_W-1:0] tuse,
        input logic [REG_W-1:0]  edst,
        input logic [TNEW_W-1:0] etnew,
        input logic [REG_W-1:0]  mdst,
        input logic [TNEW_W-1:0] mtnew
    );
        logic hit;
        hit = 1'b0;
        if (src != '0 && tuse != 2'd3) begin
            hit = (edst == src && etnew > tuse) || (mdst == src && mtnew > tuse);
        end
        return hit;
    endfunction

    // Combinational stall decision; PC/FD enables consume it this cycle.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;
        if (hz.d_valid) begin
            stall_rs = raw_hit(hz.d_rs, hz.d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
            stall_rt = raw_hit(hz.d_rt, hz.d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
            stall_md = hz.d_md_use && md_busy;
        end
    end

    assign stall      = stall_rs | stall_rt | stall_md;
    assign md_busy    = (md_count != '0);
    assign issue_md   = hz.d_valid && !stall && (hz.d_md_op != 2'b00);
    // Remaining Tnew saturates at zero as the producer moves E -> M.
    assign e_tnew_dec = (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);

    // Stage tags: E takes the D instruction or a bubble; M and W always advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst  <= '0;
            e_tnew <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            w_dst  <= '0;
        end else begin
            if (stall || !hz.d_valid) begin
                e_dst  <= '0;
                e_tnew <= '0;
            end else begin
                e_dst  <= hz.d_dst;
                e_tnew <= hz.d_tnew;
            end
            m_dst  <= e_dst;
            m_tnew <= e_tnew_dec;
            w_dst  <= m_dst;
        end
    end

    // Mult/div busy counter; a new issue overrides the decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_count <= '0;
        end else if (issue_md) begin
            md_count <= hz.d_md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_count != '0) begin
            md_count <= md_count - CNT_W'(1);
        end
    end

    assign hz.stall    = stall;
    assign hz.e_dst    = e_dst;
    assign hz.m_dst    = m_dst;
    assign hz.w_dst    = w_dst;
    assign hz.e_tnew   = e_tnew;
    assign hz.m_tnew   = m_tnew;
    assign hz.md_busy  = md_busy;
    assign hz.md_count = md_count;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed scenarios plus randomized instruction streams
// compared against a queue-based model of in-flight producers.
module tb_hazard_tracker;
    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] ur;
        logic [1:0] ut;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [1:0] mdop;
        logic       mduse;
    } instr_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
    } tag_t;

    logic clk;
    logic reset;
    hazard_tracker_if hz();

    hazard_tracker #(.MULT_CYC(MULT_C), .DIV_CYC(DIV_C)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pipe[0] = instruction in E, [1] = M, [2] = W (age = index).
    tag_t pipe[$];
    int   cyc = 0;
    int   md_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rem(input int age);
        int t;
        t = int'(pipe[age].tnew) - age;
        return (t > 0) ? t : 0;
    endfunction

    function automatic int md_left();
        return (md_done > cyc) ? md_done - cyc : 0;
    endfunction

    function automatic logic src_hit(input logic [4:0] src, input logic [1:0] tuse, input int age);
        return (src != 5'd0) && (tuse != 2'd3) && (pipe[age].dst == src) && (rem(age) > int'(tuse));
    endfunction

    function automatic logic model_stall(input instr_t d);
        logic s;
        s = 1'b0;
        if (d.v) begin
            for (int a = 0; a < 2; a++) begin
                if (src_hit(d.rs, d.ur, a) || src_hit(d.rt, d.ut, a)) s = 1'b1;
            end
            if (d.mduse && md_left() > 0) s = 1'b1;
        end
        return s;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < 3; i++) pipe.push_back(tag_t'(0));
        md_done = cyc;
    endtask

    function automatic instr_t mk(input logic v, input int rs, input int ur, input int rt,
                                  input int ut, input int dst, input int tnew,
                                  input int mdop, input logic mduse);
        instr_t d;
        d.v     = v;
        d.rs    = 5'(rs);
        d.ur    = 2'(ur);
        d.rt    = 5'(rt);
        d.ut    = 2'(ut);
        d.dst   = 5'(dst);
        d.tnew  = 2'(tnew);
        d.mdop  = 2'(mdop);
        d.mduse = mduse;
        return d;
    endfunction

    task automatic drive(input instr_t d);
        hz.d_valid   = d.v;
        hz.d_rs      = d.rs;
        hz.d_rt      = d.rt;
        hz.d_tuse_rs = d.ur;
        hz.d_tuse_rt = d.ut;
        hz.d_dst     = d.dst;
        hz.d_tnew    = d.tnew;
        hz.d_md_op   = d.mdop;
        hz.d_md_use  = d.mduse;
    endtask

    task automatic check_state(input logic exp_stall);
        chk("stall",    32'(hz.stall),    32'(exp_stall));
        chk("e_dst",    32'(hz.e_dst),    32'(pipe[0].dst));
        chk("e_tnew",   32'(hz.e_tnew),   32'(pipe[0].tnew));
        chk("m_dst",    32'(hz.m_dst),    32'(pipe[1].dst));
        chk("m_tnew",   32'(hz.m_tnew),   32'(rem(1)));
        chk("w_dst",    32'(hz.w_dst),    32'(pipe[2].dst));
        chk("md_count", 32'(hz.md_count), 32'(md_left()));
        chk("md_busy",  32'(hz.md_busy),  32'(md_left() > 0));
    endtask

    // One clock: present D, compare, take the edge, advance the model.
    task automatic cycle(input instr_t d, output logic st);
        drive(d);
        #1;
        st = model_stall(d);
        check_state(st);
        @(posedge clk);
        cyc++;
        if (d.v && !st) pipe.push_front('{dst: d.dst, tnew: d.tnew});
        else            pipe.push_front(tag_t'(0));
        void'(pipe.pop_back());
        if (d.v && !st && d.mdop != 2'd0) md_done = cyc + ((d.mdop == 2'd1) ? MULT_C : DIV_C);
        #1;
    endtask

    // Hold an instruction in D until it issues; report the stall cycles.
    task automatic issue(input instr_t d, output int n);
        logic st;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(d, st);
            if (!st) return;
            n++;
        end
        checks++;
        errors++;
        $error("FAIL issue_timeout observed=%0d expected=<30", n);
    endtask

    task automatic drain();
        logic st;
        for (int i = 0; i < 3; i++) cycle(mk(0, 0, 3, 0, 3, 0, 0, 0, 0), st);
    endtask

    instr_t nop, lw1, mflo, d;
    int     n;
    logic   st;

    initial begin
        nop  = mk(0, 0, 3, 0, 3, 0, 0, 0, 0);
        lw1  = mk(1, 2, 1, 0, 3, 1, 2, 0, 0);
        mflo = mk(1, 0, 3, 0, 3, 4, 1, 0, 1);
        drive(nop);
        reset = 1'b0;
        model_reset();
        #12;
        check_state(1'b0);
        #1 reset = 1'b1;
        drain();

        // Load-use: one bubble.
        issue(lw1, n);
        issue(mk(1, 1, 1, 0, 3, 3, 1, 0, 0), n);
        chk("load_use_stalls", 32'(n), 32'd1);
        drain();

        // Branch on ALU result: one stall; on jal $31: none.
        issue(mk(1, 5, 1, 6, 1, 1, 1, 0, 0), n);
        issue(mk(1, 1, 0, 2, 0, 0, 0, 0, 0), n);
        chk("branch_alu_stalls", 32'(n), 32'd1);
        drain();
        issue(mk(1, 0, 3, 0, 3, 31, 0, 0, 0), n);
        issue(mk(1, 31, 0, 0, 0, 0, 0, 0, 0), n);
        chk("branch_jal_stalls", 32'(n), 32'd0);
        drain();

        // Load followed by branch on the loaded register: two stalls.
        issue(lw1, n);
        issue(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), n);
        chk("branch_load_stalls", 32'(n), 32'd2);
        drain();

        // Store data forwarded from M: no stall.
        issue(lw1, n);
        issue(mk(1, 2, 1, 1, 2, 0, 0, 0, 0), n);
        chk("store_stalls", 32'(n), 32'd0);
        drain();

        // $0 is never a hazard.
        issue(mk(1, 0, 3, 0, 3, 0, 2, 0, 0), n);
        issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), n);
        chk("zero_reg_stalls", 32'(n), 32'd0);
        drain();

        // Mult then mflo; div then mflo.
        issue(mk(1, 8, 1, 9, 1, 0, 0, 1, 1), n);
        chk("mult_issue_stalls", 32'(n), 32'd0);
        issue(mflo, n);
        chk("mult_mflo_stalls", 32'(n), 32'(MULT_C));
        issue(mk(1, 8, 1, 9, 1, 0, 0, 2, 1), n);
        issue(mflo, n);
        chk("div_mflo_stalls", 32'(n), 32'(DIV_C));
        drain();

        // Async reset during the 3rd cycle of a div stall.
        issue(mk(1, 8, 1, 9, 1, 0, 0, 2, 1), n);
        issue(lw1, n);
        cycle(mflo, st);
        cycle(mflo, st);
        drive(mflo);
        #1;
        chk("pre_reset_stall", 32'(hz.stall), 32'(model_stall(mflo)));
        #1 reset = 1'b0;
        #1;
        chk("rst_stall",    32'(hz.stall),    32'd0);
        chk("rst_md_count", 32'(hz.md_count), 32'd0);
        chk("rst_md_busy",  32'(hz.md_busy),  32'd0);
        chk("rst_e_dst",    32'(hz.e_dst),    32'd0);
        chk("rst_m_dst",    32'(hz.m_dst),    32'd0);
        chk("rst_w_dst",    32'(hz.w_dst),    32'd0);
        chk("rst_tnew",     32'({hz.e_tnew, hz.m_tnew}), 32'd0);
        model_reset();
        #2 reset = 1'b1;
        issue(mflo, n);
        chk("post_reset_mflo_stalls", 32'(n), 32'd0);
        drain();

        // Randomized stream; a stalled instruction stays in D.
        st = 1'b0;
        d  = nop;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                d.v     = ($urandom_range(0, 7) != 0);
                d.rs    = 5'($urandom_range(0, 3));
                d.rt    = 5'($urandom_range(0, 3));
                d.ur    = 2'($urandom_range(0, 3));
                d.ut    = 2'($urandom_range(0, 3));
                d.dst   = 5'($urandom_range(0, 3));
                d.tnew  = 2'($urandom_range(0, 2));
                d.mdop  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
                d.mduse = (d.mdop != 2'd0) || ($urandom_range(0, 9) == 0);
            end
            cycle(d, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Producer-side companion to the forwarding selector in the five-stage pipeline. It records, for every instruction in flight in E, M and W, which GPR it writes and how many cycles remain until that value exists (Tnew). It compares these records against the D-stage instruction's source registers and use deadlines (Tuse) and raises `stall` when forwarding cannot cover the hazard. It also owns the mult/div busy counter and exports the registered stage tags that the forwarding selector consumes.

## Interface
- Parameters
  - `MULT_CYC`, default 5: busy cycles after a mult/multu leaves D.
  - `DIV_CYC`, default 10: busy cycles after a div/divu leaves D.
- Ports
  - `clk` in 1: the single clock; all state updates on the rising edge.
  - `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
  - `d_valid` in 1: the D slot holds a real instruction (0 = nop).
  - `d_rs`, `d_rt` in 5: D-stage source register numbers.
  - `d_tuse_rs`, `d_tuse_rt` in 2: cycles until the operand is needed, with 0 = D (branch/jr), 1 = E (ALU), 2 = M (store data), 3 = not read.
  - `d_dst` in 5: register written by the D instruction; 0 means no write.
  - `d_tnew` in 2: cycles after entering E until the result exists, with 0 = lui/jal, 1 = ALU, 2 = load.
  - `d_md_op` in 2: 00 = none, 01 = mult/multu, 10 = div/divu.
  - `d_md_use` in 1: the D instruction touches HI/LO or starts mult/div.
  - `stall` out 1: freeze PC and FD; insert a bubble into DE.
  - `e_dst`, `m_dst`, `w_dst` out 5: registered destination tags.
  - `e_tnew`, `m_tnew` out 2: registered remaining Tnew values.
  - `md_busy` out 1: mult/div counter is nonzero.
  - `md_count` out 4: current counter value.

## Operation
- Three tag registers:
  - E = {e_dst, e_tnew}
  - M = {m_dst, m_tnew}
  - W = {w_dst}
  - W's Tnew is always 0.
- Each edge when `stall`=0:
  - E ← (d_valid ? {d_dst, d_tnew} : {0,0}).
  - M ← {e_dst, sat(e_tnew−1)}.
  - W ← m_dst.
  - sat() clamps at 0.
- Each edge when `stall`=1:
  - E ← {0,0} (bubble).
  - M and W advance exactly as above; the pipe drains past the stall.
- RAW stall rule for the rs side, combinational:
  - The check applies when `d_valid`, d_rs≠0 and d_tuse_rs≠3.
  - stall_rs = (e_dst==d_rs && e_tnew>d_tuse_rs) || (m_dst==d_rs && m_tnew>d_tuse_rs).
  - W never stalls.
  - The rt side is identical.
- Register 0 never causes a stall and never matches as a destination, even when d_dst=0 is recorded.
- Mult/div counter:
  - When an instruction with d_md_op≠00 passes D→E (stall=0, d_valid=1), md_count loads MULT_CYC or DIV_CYC on that edge.
  - Otherwise md_count decrements while nonzero.
  - md_busy = (md_count≠0).
- stall_md = d_valid && d_md_use && md_busy.
- `stall` = stall_rs | stall_rt | stall_md.
- A load into md_count takes precedence over a decrement on the same edge.
- md_count has 4 bits; a parameter value above 15 is illegal.

## Timing
- Reset (asynchronous, on low):
  - All tags = 0 and md_count = 0.
  - Therefore `stall`=0, `md_busy`=0, and e/m/w outputs = 0.
  - A reset asserted mid-stall or mid-mult clears everything the same instant.
  - The first edge after reset release behaves as a normal advance.
- `stall`:
  - Purely combinational from the D inputs and registered state; zero-cycle latency.
  - Must settle within the same cycle so that PC/FD enables see it.
- Tag outputs are registered and change only on clk edges.
- An instruction of Tnew t entering E shows e_tnew=t for one cycle, then m_tnew=max(t−1,0), then appears on w_dst.
- Load followed immediately by a dependent ALU op (Tuse 1):
  - First cycle: e_tnew 2 > 1, stall.
  - Next cycle: the load is in M with m_tnew=1, which is not > 1, so stall=0.
  - Exactly one bubble results.
- Load followed by a branch on the loaded register (Tuse 0): two stall cycles.
- Mult issued at edge k: md_busy is high from edge k through edge k+MULT_CYC, i.e. MULT_CYC cycles.

## Test plan
- Load-use stall: lw $1 (dst1, tnew2) then addu using rs=1 (tuse1) → stall=1 for exactly 1 cycle, then e_dst=0 (bubble), m_dst=1, m_tnew=1.
- Branch after ALU op: addu $1 (tnew1) in E, beq rs=1 (tuse0) in D → stall=1 for 1 cycle. Same branch with jal's $31 (tnew0) → stall=0.
- Store data: lw $1 in E, sw rt=1 (tuse_rt=2), rs=2 (tuse_rs=1) → stall=0, sw advances.
- $0 immunity: lui $0 (dst0) in E, then a beq on $0 → stall=0 across all cycles.
- Mult/div: mult issues; mflo follows in D (d_md_use=1) → stall for 5 cycles, md_count 5,4,3,2,1,0. div → stall for 10 cycles.
- Async reset: drop reset during the 3rd cycle of a div stall → md_count=0, stall=0 and all tags 0 without waiting for clk.
